i2c_master_core: RTL and testbench

- Single-master I2C bus controller; one transfer = START, 7-bit address + R/W, one data byte, STOP or repeated START.
- Drives open-drain scl/sda shared with i2c_slave instances (e.g. addresses 0x50, 0x51) and weak pull-ups.
- Host side uses a level enable/ready handshake with ack/nack status pulses.
- No clock stretching, no multi-master arbitration.

---
 rtl/i2c_master_core.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_master_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_core.sv
// Single-master I2C controller: START, addr+R/W, one data byte, then STOP or repeated START.
// Each bit takes 4*QDIV clk cycles. ready is high only in IDLE; ack/nack pulse once per slave ACK slot.
module i2c_master_core #(
    parameter int QDIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rw,
    input  logic       restart,
    input  logic [6:0] address,
    input  logic [7:0] txdata,
    output logic [7:0] rxdata,
    output logic       ack,
    output logic       nack,
    output logic       ready,
    inout  wire        scl,
    inout  wire        sda
);

    localparam int DW = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, RDATA, DACK, RESTART, STOP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          smp_q, smp_d;
    logic          scl_low_q, scl_low_d;
    logic          sda_low_q, sda_low_d;

    logic          sda_in;
    logic          tick;
    logic          sample;
    logic          last;
    logic [7:0]    out_byte;
    logic          out_bit;

    assign sda_in = sda;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        tx_d     = tx_q;
        shift_d  = shift_q;
        rxdata_d = rxdata_q;
        smp_d    = smp_q;
        ack_d    = 1'b0;
        nack_d   = 1'b0;

        tick   = (div_q == DW'(QDIV - 1));
        sample = tick && (phase_q == 2'd1);
        last   = tick && (phase_q == 2'd3);
        div_d  = tick ? '0 : div_q + DW'(1);
        if (tick) begin
            phase_d = phase_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                div_d   = '0;
                phase_d = 2'd0;
                bit_d   = 3'd0;
                if (enable) begin
                    addr_d  = address;
                    rw_d    = rw;
                    tx_d    = txdata;
                    state_d = START;
                end
            end
            START: begin
                if (last) state_d = ADDR;
            end
            ADDR, WDATA: begin
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == ADDR) ? AACK : DACK;
                end
            end
            AACK: begin
                if (sample) begin
                    smp_d  = sda_in;
                    ack_d  = ~sda_in;
                    nack_d = sda_in;
                end
                if (last) state_d = smp_q ? STOP : (rw_q ? RDATA : WDATA);
            end
            RDATA: begin
                if (sample) begin
                    shift_d = {shift_q[6:0], sda_in};
                    if (bit_q == 3'd7) rxdata_d = {shift_q[6:0], sda_in};
                end
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = DACK;
                end
            end
            DACK: begin
                // After a read the master itself NACKs, which is not reported.
                if (sample && !rw_q) begin
                    ack_d  = ~sda_in;
                    nack_d = sda_in;
                end
                if (last) state_d = restart ? RESTART : STOP;
            end
            RESTART: begin
                if (last) begin
                    addr_d  = address;
                    rw_d    = rw;
                    tx_d    = txdata;
                    state_d = START;
                end
            end
            STOP: begin
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus drive is registered from the next state so the pins never glitch.
    always_comb begin
        out_byte  = (state_d == WDATA) ? tx_d : {addr_d, rw_d};
        out_bit   = out_byte[~bit_d];
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            START: begin
                scl_low_d = phase_d[1];
                sda_low_d = 1'b1;
            end
            ADDR, WDATA: begin
                scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_low_d = ~out_bit;
            end
            AACK, RDATA, DACK: begin
                scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
            end
            RESTART: begin
                scl_low_d = (phase_d == 2'd0);
            end
            STOP: begin
                scl_low_d = (phase_d == 2'd0);
                sda_low_d = ~phase_d[1];
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            div_q     <= '0;
            addr_q    <= 7'd0;
            rw_q      <= 1'b0;
            tx_q      <= 8'd0;
            shift_q   <= 8'd0;
            rxdata_q  <= 8'd0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            smp_q     <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            rxdata_q  <= rxdata_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            smp_q     <= smp_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign scl    = scl_low_q ? 1'b0 : 1'bz;
    assign sda    = sda_low_q ? 1'b0 : 1'bz;
    assign ready  = (state_q == IDLE);
    assign ack    = ack_q;
    assign nack   = nack_q;
    assign rxdata = rxdata_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core: behavioural slave at 0x50/0x51 plus a bus monitor
// that records 9-bit frames ({byte, ack bit}) and START/STOP events.
module tb_i2c_master_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       rw;
    logic       restart;
    logic [6:0] address;
    logic [7:0] txdata;
    logic [7:0] rxdata;
    logic       ack;
    logic       nack;
    logic       ready;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);

    logic slv_low = 1'b0;
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_core #(.QDIV(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .rw      (rw),
        .restart (restart),
        .address (address),
        .txdata  (txdata),
        .rxdata  (rxdata),
        .ack     (ack),
        .nack    (nack),
        .ready   (ready),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    typedef enum {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK} slv_t;

    slv_t        slv_st   = S_IDLE;
    logic        ps       = 1'b1;
    logic        pd       = 1'b1;
    int          scnt     = 0;
    int          mcnt     = 0;
    logic [7:0]  sshift   = 8'h00;
    logic [7:0]  slv_rx   = 8'h00;
    logic [7:0]  slv_tx   = 8'hBB;
    logic        srw      = 1'b0;
    logic [8:0]  mshift   = 9'h000;
    logic [8:0]  frames[$];
    logic [31:0] ev       = 32'h0;
    int          starts   = 0;
    int          ack_cnt  = 0;
    int          nack_cnt = 0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always @(negedge clk) begin : bus_model
        logic s_v, d_v;
        s_v = scl;
        d_v = sda;
        if (ack)  ack_cnt++;
        if (nack) nack_cnt++;
        if (ps && s_v && pd && !d_v) begin
            ev = {ev[29:0], 2'b01};
            starts++;
            mcnt = 0;
            scnt = 0;
            slv_st = S_ADDR;
            slv_low = 1'b0;
        end else if (ps && s_v && !pd && d_v) begin
            ev = {ev[29:0], 2'b10};
            mcnt = 0;
            slv_st = S_IDLE;
            slv_low = 1'b0;
        end else if (!ps && s_v) begin
            mshift = {mshift[7:0], d_v};
            mcnt++;
            if (mcnt == 9) begin
                frames.push_back(mshift);
                mcnt = 0;
            end
            if (slv_st == S_ADDR || slv_st == S_WR) begin
                sshift = {sshift[6:0], d_v};
                scnt++;
            end
        end else if (ps && !s_v) begin
            case (slv_st)
                S_ADDR: if (scnt == 8) begin
                    if (sshift[7:1] == 7'h50 || sshift[7:1] == 7'h51) begin
                        slv_low = 1'b1;
                        srw = sshift[0];
                        slv_st = S_AACK;
                    end else begin
                        slv_st = S_IDLE;
                    end
                end
                S_AACK: begin
                    scnt = 0;
                    if (srw) begin
                        slv_low = !slv_tx[7];
                        scnt = 1;
                        slv_st = S_RD;
                    end else begin
                        slv_low = 1'b0;
                        slv_st = S_WR;
                    end
                end
                S_WR: if (scnt == 8) begin
                    slv_rx = sshift;
                    slv_low = 1'b1;
                    slv_st = S_WACK;
                end
                S_RD: begin
                    if (scnt == 8) begin
                        slv_low = 1'b0;
                        slv_st = S_RACK;
                    end else begin
                        slv_low = !slv_tx[7 - scnt];
                        scnt++;
                    end
                end
                S_WACK, S_RACK: begin
                    slv_low = 1'b0;
                    slv_st = S_IDLE;
                end
                default: ;
            endcase
        end
        ps = s_v;
        pd = d_v;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [6:0] a, input logic r, input logic [7:0] t, input logic rs);
        @(negedge clk);
        address = a;
        rw      = r;
        txdata  = t;
        restart = rs;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int fb, ab, nb, sb, n;
        reset_n = 1'b1;
        enable  = 1'b0;
        rw      = 1'b0;
        restart = 1'b0;
        address = 7'h00;
        txdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_ack",   {31'd0, ack},   32'd0);
        check("rst_nack",  {31'd0, nack},  32'd0);
        check("rst_rxdata", {24'd0, rxdata}, 32'h00);
        check("rst_scl",   {31'd0, scl},   32'd1);
        check("rst_sda",   {31'd0, sda},   32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write 0xFE to 0x50
        fb = frames.size(); ab = ack_cnt; nb = nack_cnt;
        start_xfer(7'h50, 1'b0, 8'hFE, 1'b0);
        check("wr_busy", {31'd0, ready}, 32'd0);
        wait_ready("wr_done");
        check("wr_nframes", frames.size() - fb, 32'd2);
        check("wr_addr_frame", {23'd0, frames[fb]}, {23'd0, 8'hA0, 1'b0});
        check("wr_data_frame", {23'd0, frames[fb+1]}, {23'd0, 8'hFE, 1'b0});
        check("wr_acks", ack_cnt - ab, 32'd2);
        check("wr_nacks", nack_cnt - nb, 32'd0);
        check("wr_slv_rx", {24'd0, slv_rx}, 32'hFE);
        check("wr_events", {28'd0, ev[3:0]}, 32'b0110);
        check("wr_rxdata_hold", {24'd0, rxdata}, 32'h00);

        // Read from 0x51, slave returns 0xBB
        fb = frames.size(); ab = ack_cnt; nb = nack_cnt;
        start_xfer(7'h51, 1'b1, 8'h00, 1'b0);
        wait_ready("rd_done");
        check("rd_nframes", frames.size() - fb, 32'd2);
        check("rd_addr_frame", {23'd0, frames[fb]}, {23'd0, 8'hA3, 1'b0});
        check("rd_data_frame", {23'd0, frames[fb+1]}, {23'd0, 8'hBB, 1'b1});
        check("rd_acks", ack_cnt - ab, 32'd1);
        check("rd_nacks", nack_cnt - nb, 32'd0);
        check("rd_rxdata", {24'd0, rxdata}, 32'hBB);
        check("rd_events", {28'd0, ev[3:0]}, 32'b0110);

        // No slave at 0x33
        fb = frames.size(); ab = ack_cnt; nb = nack_cnt;
        start_xfer(7'h33, 1'b0, 8'h55, 1'b0);
        wait_ready("nk_done");
        check("nk_nframes", frames.size() - fb, 32'd1);
        check("nk_addr_frame", {23'd0, frames[fb]}, {23'd0, 8'h66, 1'b1});
        check("nk_acks", ack_cnt - ab, 32'd0);
        check("nk_nacks", nack_cnt - nb, 32'd1);
        check("nk_rxdata_hold", {24'd0, rxdata}, 32'hBB);
        check("nk_events", {28'd0, ev[3:0]}, 32'b0110);

        // Repeated START: write 0x12 to 0x50, then read 0x51
        slv_tx = 8'h5C;
        fb = frames.size(); ab = ack_cnt; sb = starts;
        start_xfer(7'h50, 1'b0, 8'h12, 1'b1);
        address = 7'h51;
        rw = 1'b1;
        n = 0;
        while ((starts - sb) < 2 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rs_second_start", starts - sb, 32'd2);
        restart = 1'b0;
        wait_ready("rs_done");
        check("rs_nframes", frames.size() - fb, 32'd4);
        check("rs_frame0", {23'd0, frames[fb]},   {23'd0, 8'hA0, 1'b0});
        check("rs_frame1", {23'd0, frames[fb+1]}, {23'd0, 8'h12, 1'b0});
        check("rs_frame2", {23'd0, frames[fb+2]}, {23'd0, 8'hA3, 1'b0});
        check("rs_frame3", {23'd0, frames[fb+3]}, {23'd0, 8'h5C, 1'b1});
        check("rs_events", {26'd0, ev[5:0]}, 32'b010110);
        check("rs_acks", ack_cnt - ab, 32'd3);
        check("rs_slv_rx", {24'd0, slv_rx}, 32'h12);
        check("rs_rxdata", {24'd0, rxdata}, 32'h5C);

        // Reset in the middle of the address byte
        start_xfer(7'h50, 1'b0, 8'hAA, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr_scl", {31'd0, scl}, 32'd1);
        check("mr_sda", {31'd0, sda}, 32'd1);
        check("mr_ready", {31'd0, ready}, 32'd1);
        check("mr_ack", {31'd0, ack}, 32'd0);
        check("mr_nack", {31'd0, nack}, 32'd0);
        check("mr_rxdata", {24'd0, rxdata}, 32'h00);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        fb = frames.size(); ab = ack_cnt;
        start_xfer(7'h51, 1'b0, 8'h3C, 1'b0);
        wait_ready("mr_clean_done");
        check("mr_nframes", frames.size() - fb, 32'd2);
        check("mr_frame0", {23'd0, frames[fb]},   {23'd0, 8'hA2, 1'b0});
        check("mr_frame1", {23'd0, frames[fb+1]}, {23'd0, 8'h3C, 1'b0});
        check("mr_acks", ack_cnt - ab, 32'd2);
        check("mr_slv_rx", {24'd0, slv_rx}, 32'h3C);
        check("mr_events", {28'd0, ev[3:0]}, 32'b0110);

        // enable held high: write 0x77 to 0x50, then read 0x51 back to back
        fb = frames.size(); ab = ack_cnt;
        @(negedge clk);
        address = 7'h50;
        rw      = 1'b0;
        txdata  = 8'h77;
        restart = 1'b0;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        check("bb_busy", {31'd0, ready}, 32'd0);
        address = 7'h51;
        rw      = 1'b1;
        wait_ready("bb_gap");
        @(posedge clk);
        #1;
        check("bb_ready_pulse", {31'd0, ready}, 32'd0);
        enable = 1'b0;
        wait_ready("bb_done");
        check("bb_nframes", frames.size() - fb, 32'd4);
        check("bb_frame0", {23'd0, frames[fb]},   {23'd0, 8'hA0, 1'b0});
        check("bb_frame1", {23'd0, frames[fb+1]}, {23'd0, 8'h77, 1'b0});
        check("bb_frame2", {23'd0, frames[fb+2]}, {23'd0, 8'hA3, 1'b0});
        check("bb_frame3", {23'd0, frames[fb+3]}, {23'd0, 8'h5C, 1'b1});
        check("bb_events", {24'd0, ev[7:0]}, 32'b01100110);
        check("bb_acks", ack_cnt - ab, 32'd3);
        check("bb_slv_rx", {24'd0, slv_rx}, 32'h77);
        check("bb_rxdata", {24'd0, rxdata}, 32'h5C);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
